// File: rtl/shift_pkg.sv
// Shared types and small helpers for the pipelined shift/rotate unit.
package shift_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOGICAL = 2'b00,
        OP_ARITH   = 2'b01,
        OP_ROTATE  = 2'b10,
        OP_REVERSE = 2'b11
    } shift_op_t;

    // The core only shifts left; right ops and REVERSE mirror the operand first.
    function automatic logic pre_reverse(input shift_op_t op, input logic lr);
        return (op == OP_REVERSE) || !lr;
    endfunction

    // REVERSE is finished by the input mirror alone, other right ops mirror back.
    function automatic logic post_reverse(input shift_op_t op, input logic lr);
        return (op != OP_REVERSE) && !lr;
    endfunction

    function automatic logic arith_fill(input shift_op_t op, input logic lr, input logic msb);
        return (op == OP_ARITH) && !lr && msb;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditional left shift/rotate by 2**K plus sideband registers.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int unsigned N = 3,
    parameter  int unsigned K = 0,
    localparam int unsigned W = 2**N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [W-1:0]    i_data,
    input  logic [N-1:0]    i_amt,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_lr,
    input  logic            i_fill,
    output logic            o_valid,
    output logic [W-1:0]    o_data,
    output logic [N-1:0]    o_amt,
    output logic [OP_W-1:0] o_op,
    output logic            o_lr,
    output logic            o_fill
);

    localparam int unsigned S = 2**K;

    logic            r_valid;
    logic [W-1:0]    r_data;
    logic [N-1:0]    r_amt;
    logic [OP_W-1:0] r_op;
    logic            r_lr;
    logic            r_fill;
    logic [W-1:0]    w_shifted;

    always_comb begin
        w_shifted = i_data;
        if (i_amt[K]) begin
            if (shift_op_t'(i_op) == OP_ROTATE) begin
                w_shifted = {i_data[W-1-S:0], i_data[W-1:W-S]};
            end else begin
                w_shifted = {i_data[W-1-S:0], {S{i_fill}}};
            end
        end
    end

    // Flush drops only the valid flag; payload of an invalid stage is don't-care.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= '0;
            r_lr    <= 1'b0;
            r_fill  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_shifted;
            r_amt   <= i_amt;
            r_op    <= i_op;
            r_lr    <= i_lr;
            r_fill  <= i_fill;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_op    = r_op;
    assign o_lr    = r_lr;
    assign o_fill  = r_fill;

endmodule

// File: rtl/pipelined_shift_rotate_unit.sv
// N-stage logarithmic shifter with valid/ready flow control, global stall and flush.
module pipelined_shift_rotate_unit
    import shift_pkg::*;
#(
    parameter  int unsigned N = 3,
    localparam int unsigned W = 2**N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] data_in,
    input  logic [N-1:0] amount,
    input  logic         lr,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data_out,
    output logic [N-1:0] occupancy
);

    // Index 0 is the pre-processed input, index k+1 is the output of stage k.
    logic [N:0]           w_valid;
    logic [N:0][W-1:0]    w_data;
    logic [N:0][N-1:0]    w_amt;
    logic [N:0][OP_W-1:0] w_op;
    logic [N:0]           w_lr;
    logic [N:0]           w_fill;

    shift_op_t    w_op_in;
    logic         w_advance;
    logic         w_accept;
    logic         w_emit;
    logic [W-1:0] w_rev_in;
    logic [W-1:0] w_rev_out;
    logic         w_unused_tail;
    logic [N-1:0] r_occupancy;

    assign w_op_in   = shift_op_t'(op);
    assign w_advance = !w_valid[N] || out_ready;
    assign in_ready  = w_advance && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_emit    = w_valid[N] && out_ready;

    always_comb begin
        w_rev_in  = '0;
        w_rev_out = '0;
        for (int i = 0; i < W; i++) begin
            w_rev_in[i]  = data_in[W-1-i];
            w_rev_out[i] = w_data[N][W-1-i];
        end
    end

    assign w_valid[0] = w_accept;
    assign w_data[0]  = pre_reverse(w_op_in, lr) ? w_rev_in : data_in;
    assign w_amt[0]   = (w_op_in == OP_REVERSE) ? '0 : amount;
    assign w_op[0]    = op;
    assign w_lr[0]    = lr;
    assign w_fill[0]  = arith_fill(w_op_in, lr, data_in[W-1]);

    for (genvar k = 0; k < N; k++) begin : g_stage
        shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_en    (w_advance),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_amt   (w_amt[k]),
            .i_op    (w_op[k]),
            .i_lr    (w_lr[k]),
            .i_fill  (w_fill[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_op    (w_op[k+1]),
            .o_lr    (w_lr[k+1]),
            .o_fill  (w_fill[k+1])
        );
    end

    // Amount and fill are fully consumed by the last stage.
    assign w_unused_tail = ^{w_amt[N], w_fill[N]};

    assign out_valid = w_valid[N];
    assign data_out  = post_reverse(shift_op_t'(w_op[N]), w_lr[N]) ? w_rev_out : w_data[N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else if (w_accept && !w_emit) begin
            r_occupancy <= r_occupancy + N'(1);
        end else if (!w_accept && w_emit) begin
            r_occupancy <= r_occupancy - N'(1);
        end
    end

    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_pipelined_shift_rotate_unit.sv
// Bench for pipelined_shift_rotate_unit: queue-based transaction model plus literal vectors.
module tb_pipelined_shift_rotate_unit;

    localparam int unsigned N = 3;
    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic [N-1:0] amount;
    logic         lr;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [N-1:0] occupancy;

    pipelined_shift_rotate_unit #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .amount    (amount),
        .lr        (lr),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           age;
        int           cyc;
        bit           has_lit;
        logic [W-1:0] lit;
    } item_t;

    item_t        q[$];
    int           total = 0;
    int           bad = 0;
    bit           lit_arm;
    logic [W-1:0] lit_val;
    int           rdy_mode;
    int           hold_cnt;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a,
                                           input logic l, input logic [1:0] o);
        logic [W-1:0]        r;
        logic signed [W-1:0] s;
        r = '0;
        case (o)
            2'b00: r = l ? (d << a) : (d >> a);
            2'b01: begin
                s = d;
                r = l ? (d << a) : W'(s >>> a);
            end
            2'b10: r = l ? ((d << a) | (d >> (W - a))) : ((d >> a) | (d << (W - a)));
            default: for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs sampled mid-cycle; model then steps to what the next edge will do.
    always @(negedge clk) begin : cmp
        bit    exp_ov;
        bit    exp_adv;
        item_t it;
        if (reset) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_occupancy", 32'(occupancy), 32'd0);
            chk("rst_data_out", 32'(data_out), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'(!flush));
        end else begin
            exp_ov  = (q.size() > 0) && (q[0].age == N);
            exp_adv = !exp_ov || out_ready;
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready), 32'(exp_adv && !flush));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            if (exp_ov) chk("data_out", 32'(data_out), 32'(q[0].val));
            foreach (q[i]) begin
                if (q[i].has_lit && q[i].cyc == 3) begin
                    chk("lit_latency", 32'(out_valid), 32'd1);
                    chk("lit_data", 32'(data_out), 32'(q[i].lit));
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_adv && exp_ov) void'(q.pop_front());
                foreach (q[i]) begin
                    if (exp_adv) q[i].age++;
                    q[i].cyc++;
                end
                if (exp_adv && in_valid) begin
                    it.val     = model(data_in, int'(amount), lr, op);
                    it.age     = 1;
                    it.cyc     = 1;
                    it.has_lit = lit_arm;
                    it.lit     = lit_val;
                    if (lit_arm) chk("model_pin", 32'(it.val), 32'(lit_val));
                    q.push_back(it);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic send(input logic [W-1:0] d, input logic [N-1:0] a,
                        input logic l, input logic [1:0] o);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        data_in  = d;
        amount   = a;
        lr       = l;
        op       = o;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) begin
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles at %0t", $time);
            $fatal(1, "input never accepted");
        end
        in_valid = 1'b0;
        lit_arm  = 1'b0;
    endtask

    task automatic send_lit(input logic [W-1:0] d, input logic [N-1:0] a, input logic l,
                            input logic [1:0] o, input logic [W-1:0] exp);
        rdy_mode = 0;
        lit_val  = exp;
        lit_arm  = 1'b1;
        send(d, a, l, o);
        repeat (5) step();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        amount    = '0;
        lr        = 1'b0;
        op        = 2'b00;
        out_ready = 1'b1;
        rdy_mode  = 0;
        hold_cnt  = 0;
        lit_arm   = 1'b0;
        lit_val   = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        step();

        send_lit(8'h96, 3'd3, 1'b1, 2'b00, 8'hB0);
        send_lit(8'h96, 3'd2, 1'b0, 2'b01, 8'hE5);
        send_lit(8'h96, 3'd1, 1'b0, 2'b10, 8'h4B);
        send_lit(8'hA1, 3'd5, 1'b1, 2'b11, 8'h85);
        send_lit(8'h5A, 3'd0, 1'b0, 2'b10, 8'h5A);
        send_lit(8'h80, 3'd7, 1'b0, 2'b01, 8'hFF);
        send_lit(8'h80, 3'd7, 1'b0, 2'b00, 8'h01);
        send_lit(8'h01, 3'd7, 1'b1, 2'b10, 8'h80);
        send_lit(8'h3C, 3'd0, 1'b1, 2'b01, 8'h3C);

        // Backpressure: downstream stalls while eight ops are streamed in.
        out_ready = 1'b0;
        hold_cnt  = 5;
        rdy_mode  = 2;
        for (int i = 0; i < 8; i++) begin
            send(W'(i * 37 + 3), N'(i), i[0], 2'(i));
        end
        rdy_mode = 0;
        repeat (8) step();

        // Flush with two ops in flight and a new one on offer.
        rdy_mode  = 2;
        hold_cnt  = 1000;
        out_ready = 1'b0;
        send(8'hC3, 3'd1, 1'b1, 2'b00);
        send(8'h7E, 3'd2, 1'b0, 2'b01);
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'hE7;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        hold_cnt = 0;
        repeat (3) step();

        // Asynchronous reset mid-stream, between clock edges.
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) begin
            send(W'(i * 53 + 9), N'(i + 2), i[1], 2'(i + 1));
        end
        #1 reset = 1'b1;
        repeat (2) step();
        #1 reset = 1'b0;
        rdy_mode = 0;
        step();
        send_lit(8'h96, 3'd3, 1'b1, 2'b00, 8'hB0);

        // Full sweep under random downstream readiness.
        rdy_mode = 1;
        for (int o = 0; o < 4; o++) begin
            for (int l = 0; l < 2; l++) begin
                for (int a = 0; a < 8; a++) begin
                    for (int d = 0; d < 256; d++) begin
                        send(W'(d), N'(a), l[0], 2'(o));
                    end
                end
            end
        end
        rdy_mode = 0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
